// File: rtl/apb_slave_regbank.sv
// APB completer serving an 8 x 32-bit register bank with programmable
// wait states, error responses, W1C interrupt status and a write counter.
module apb_slave_regbank #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic        Pclk,
   input  logic        Preset,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr,
   input  logic [31:0] status_in,
   input  logic [7:0]  event_in,
   output logic [31:0] ctrl_out,
   output logic        irq
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

   logic [0:0]  state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] gp_q, gp_d;
   logic [7:0]  irq_stat_q, irq_stat_d;
   logic [7:0]  irq_en_q, irq_en_d;
   logic [15:0] wcount_q, wcount_d;
   logic        irq_q, irq_d;

   logic [2:0]  reg_idx;
   logic        ro_hit;
   logic        acc_err;
   logic        complete;
   logic        wr_ok;
   logic [7:0]  w1c_mask;
   logic [31:0] rd_mux;
   logic        unused_paddr;

   assign reg_idx      = Paddr[4:2];
   assign unused_paddr = ^Paddr[31:5];

   assign ro_hit   = (reg_idx == 3'd1) || (reg_idx == 3'd5) || (reg_idx == 3'd7);
   assign acc_err  = (Paddr[1:0] != 2'b00) || (Pwrite && ro_hit);
   assign complete = (state_q == ST_ACCESS) && (wait_cnt_q == 4'd0) && Psel && Penable;
   assign wr_ok    = complete && Pwrite && !acc_err;

   // Transfer sequencing: setup detection, wait-state countdown, abort on Psel drop
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Psel && !Penable) begin
               state_d    = ST_ACCESS;
               wait_cnt_d = WAIT_INIT;
            end
         end
         ST_ACCESS: begin
            if (!Psel) begin
               state_d    = ST_IDLE;
               wait_cnt_d = '0;
            end else if (Penable) begin
               if (wait_cnt_q == 4'd0) begin
                  state_d = ST_IDLE;
               end else begin
                  wait_cnt_d = wait_cnt_q - 4'd1;
               end
            end
         end
         default: begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Register updates on successful writes, event capture and interrupt level
   always_comb begin
      ctrl_d    = ctrl_q;
      scratch_d = scratch_q;
      gp_d      = gp_q;
      irq_en_d  = irq_en_q;
      w1c_mask  = '0;
      if (wr_ok) begin
         case (reg_idx)
            3'd0:    ctrl_d    = Pwdata;
            3'd2:    scratch_d = Pwdata;
            3'd3:    w1c_mask  = Pwdata[7:0];
            3'd4:    irq_en_d  = Pwdata[7:0];
            3'd6:    gp_d      = Pwdata;
            default: ;
         endcase
      end
      // new events are OR-ed in after the clear so a coincident set wins
      irq_stat_d = (irq_stat_q & ~w1c_mask) | event_in;
      wcount_d   = wcount_q + {15'd0, wr_ok};
      irq_d      = |(irq_stat_q & irq_en_q);
   end

   // Read data selection by register index
   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         3'd0:    rd_mux = ctrl_q;
         3'd1:    rd_mux = status_in;
         3'd2:    rd_mux = scratch_q;
         3'd3:    rd_mux = {24'd0, irq_stat_q};
         3'd4:    rd_mux = {24'd0, irq_en_q};
         3'd5:    rd_mux = {16'd0, wcount_q};
         3'd6:    rd_mux = gp_q;
         default: rd_mux = ID_VALUE;
      endcase
   end

   // State and register storage with synchronous reset
   always_ff @(posedge Pclk) begin
      if (Preset) begin
         state_q    <= ST_IDLE;
         wait_cnt_q <= '0;
         ctrl_q     <= '0;
         scratch_q  <= '0;
         gp_q       <= '0;
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         wcount_q   <= '0;
         irq_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         ctrl_q     <= ctrl_d;
         scratch_q  <= scratch_d;
         gp_q       <= gp_d;
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         wcount_q   <= wcount_d;
         irq_q      <= irq_d;
      end
   end

   assign Pready   = complete;
   assign Pslverr  = complete && acc_err;
   assign Prdata   = (complete && !Pwrite && !acc_err) ? rd_mux : '0;
   assign ctrl_out = ctrl_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Bench for apb_slave_regbank: two instances (one and zero wait states) on a
// shared master, a transfer-level reference model and directed literal checks.
module tb_apb_slave_regbank;

   logic        Pclk = 1'b0;
   logic        Preset = 1'b1;
   logic        m_psel = 1'b0, m_pen = 1'b0, m_write = 1'b0, m_tgt = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0;
   logic [31:0] status_in = '0;
   logic [7:0]  event_in = '0;

   logic        psel_w  [2];
   logic [31:0] prdata_w[2];
   logic        rdy_w   [2];
   logic        err_w   [2];
   logic [31:0] ctrl_w  [2];
   logic        irq_w   [2];

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus side-channel controls
   logic        ev_rand = 1'b0, st_rand = 1'b0, preload = 1'b0;
   logic [7:0]  ev_val = '0;
   logic [31:0] st_val = 32'h1234_5678;

   // reference model state, one slot per instance
   int          ws[2] = '{1, 0};
   logic [31:0] m_ctrl[2], m_scr[2], m_gp[2];
   logic [7:0]  m_stat[2], m_en[2];
   logic [15:0] m_wc[2];
   logic        m_irq[2];
   bit          m_inx[2];
   int          m_acc[2];
   bit          m_valid = 1'b0;

   assign psel_w[0] = m_psel & ~m_tgt;
   assign psel_w[1] = m_psel & m_tgt;

   apb_slave_regbank #(.WAIT_STATES(1), .ID_VALUE(32'hA5B0_0001)) dut_a (
      .Pclk(Pclk), .Preset(Preset), .Psel(psel_w[0]), .Penable(m_pen), .Pwrite(m_write),
      .Paddr(m_addr), .Pwdata(m_wdata), .Prdata(prdata_w[0]), .Pready(rdy_w[0]),
      .Pslverr(err_w[0]), .status_in(status_in), .event_in(event_in),
      .ctrl_out(ctrl_w[0]), .irq(irq_w[0]));

   apb_slave_regbank #(.WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) dut_b (
      .Pclk(Pclk), .Preset(Preset), .Psel(psel_w[1]), .Penable(m_pen), .Pwrite(m_write),
      .Paddr(m_addr), .Pwdata(m_wdata), .Prdata(prdata_w[1]), .Pready(rdy_w[1]),
      .Pslverr(err_w[1]), .status_in(status_in), .event_in(event_in),
      .ctrl_out(ctrl_w[1]), .irq(irq_w[1]));

   initial forever #5 Pclk = ~Pclk;

   task automatic chk(input string nm, input int inst, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   // event and status drivers, updated shortly after each rising edge
   initial forever begin
      @(posedge Pclk);
      #2;
      if (ev_rand) event_in = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      else         event_in = ev_val;
      status_in = st_rand ? $urandom : st_val;
   end

   // reference model: check this cycle's outputs, then advance to the next edge
   initial forever begin
      logic        sel, erdy, eerr;
      logic [2:0]  ix;
      logic [31:0] erd;
      logic [7:0]  clr;
      @(negedge Pclk);
      for (int i = 0; i < 2; i++) begin
         sel  = psel_w[i];
         ix   = m_addr[4:2];
         erdy = m_inx[i] && sel && m_pen && (m_acc[i] == ws[i]);
         eerr = erdy && ((m_addr[1:0] != 2'b00) ||
                         (m_write && (ix == 3'd1 || ix == 3'd5 || ix == 3'd7)));
         erd  = '0;
         if (erdy && !eerr && !m_write) begin
            case (ix)
               3'd0: erd = m_ctrl[i];
               3'd1: erd = status_in;
               3'd2: erd = m_scr[i];
               3'd3: erd = {24'd0, m_stat[i]};
               3'd4: erd = {24'd0, m_en[i]};
               3'd5: erd = {16'd0, m_wc[i]};
               3'd6: erd = m_gp[i];
               default: erd = 32'hA5B0_0001;
            endcase
         end
         if (m_valid) begin
            chk("pready",   i, 32'(rdy_w[i]), 32'(erdy));
            chk("pslverr",  i, 32'(err_w[i]), 32'(eerr));
            chk("prdata",   i, prdata_w[i],   erd);
            chk("ctrl_out", i, ctrl_w[i],     m_ctrl[i]);
            chk("irq",      i, 32'(irq_w[i]), 32'(m_irq[i]));
         end
         if (Preset) begin
            m_ctrl[i] = '0; m_scr[i] = '0; m_gp[i] = '0; m_stat[i] = '0;
            m_en[i] = '0; m_wc[i] = '0; m_irq[i] = 1'b0; m_inx[i] = 1'b0; m_acc[i] = 0;
         end else begin
            m_irq[i] = |(m_stat[i] & m_en[i]);
            clr = '0;
            if (erdy && m_write && !eerr) begin
               case (ix)
                  3'd0: m_ctrl[i] = m_wdata;
                  3'd2: m_scr[i]  = m_wdata;
                  3'd3: clr       = m_wdata[7:0];
                  3'd4: m_en[i]   = m_wdata[7:0];
                  3'd6: m_gp[i]   = m_wdata;
                  default: ;
               endcase
               m_wc[i] = m_wc[i] + 16'd1;
            end
            m_stat[i] = (m_stat[i] & ~clr) | event_in;
            if (!m_inx[i]) begin
               if (sel && !m_pen) begin m_inx[i] = 1'b1; m_acc[i] = 0; end
            end else if (!sel) begin
               m_inx[i] = 1'b0;
            end else if (m_pen) begin
               if (erdy) m_inx[i] = 1'b0;
               else      m_acc[i] = m_acc[i] + 1;
            end
            if (preload && i == 1) m_wc[1] = 16'hFFFE;
         end
      end
      if (Preset) m_valid = 1'b1;
   end

   task automatic apb(input logic tgt, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic err,
                      output int waits);
      bit done;
      @(posedge Pclk); #1;
      m_tgt = tgt; m_psel = 1'b1; m_pen = 1'b0; m_write = wr; m_addr = addr; m_wdata = wd;
      @(posedge Pclk); #1;
      m_pen = 1'b1;
      waits = 0; rd = '0; err = 1'b0; done = 1'b0;
      while (!done) begin
         @(negedge Pclk);
         if (tgt ? rdy_w[1] : rdy_w[0]) begin
            rd   = tgt ? prdata_w[1] : prdata_w[0];
            err  = tgt ? err_w[1] : err_w[0];
            done = 1'b1;
         end else begin
            waits++;
            if (waits > 40) begin
               n_cmp++; n_bad++;
               $display("FAIL pready_timeout dut%0d: no Pready after %0d cycles", tgt, waits);
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic bus_idle();
      @(posedge Pclk); #1;
      m_psel = 1'b0; m_pen = 1'b0;
   endtask

   task automatic abort_wr(input logic [31:0] addr, input logic [31:0] wd);
      @(posedge Pclk); #1;
      m_tgt = 1'b0; m_psel = 1'b1; m_pen = 1'b0; m_write = 1'b1; m_addr = addr; m_wdata = wd;
      @(posedge Pclk); #1;
      m_pen = 1'b1;
      @(negedge Pclk);
      chk("abort_wait_state", 0, 32'(rdy_w[0]), 32'd0);
      @(posedge Pclk); #1;
      m_psel = 1'b0; m_pen = 1'b0;
   endtask

   initial begin
      logic [31:0] rd, addr;
      logic        er, tgt, wr;
      int          wt;

      repeat (3) @(posedge Pclk);
      #1 Preset = 1'b0;
      @(negedge Pclk);
      chk("reset_pready", 0, 32'(rdy_w[0]), 32'd0);
      chk("reset_ctrl",   0, ctrl_w[0], 32'd0);
      chk("reset_irq",    1, 32'(irq_w[1]), 32'd0);

      // ID read with one wait state
      apb(1'b0, 1'b0, 32'h0000_001C, '0, rd, er, wt);
      chk("id_waits", 0, 32'(wt), 32'd1);
      chk("id_data",  0, rd, 32'hA5B0_0001);
      chk("id_err",   0, 32'(er), 32'd0);

      // CTRL write / read back, back-to-back transfers
      apb(1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, rd, er, wt);
      apb(1'b0, 1'b0, 32'h0000_0000, '0, rd, er, wt);
      chk("ctrl_out",  0, ctrl_w[0], 32'hDEAD_BEEF);
      chk("ctrl_read", 0, rd, 32'hDEAD_BEEF);
      apb(1'b0, 1'b0, 32'h0000_0014, '0, rd, er, wt);
      chk("wcount_1", 0, rd, 32'd1);

      // error paths
      apb(1'b0, 1'b1, 32'h0000_0004, 32'h5555_5555, rd, er, wt);
      chk("ro_write_err", 0, 32'(er), 32'd1);
      apb(1'b0, 1'b1, 32'h0000_0002, 32'h6666_6666, rd, er, wt);
      chk("misaligned_err", 0, 32'(er), 32'd1);
      apb(1'b0, 1'b0, 32'h0000_0014, '0, rd, er, wt);
      chk("wcount_after_err", 0, rd, 32'd1);
      apb(1'b0, 1'b0, 32'h0000_0004, '0, rd, er, wt);
      chk("status_read", 0, rd, 32'h1234_5678);
      apb(1'b0, 1'b0, 32'h0000_0009, '0, rd, er, wt);
      chk("misaligned_rd_err",  0, 32'(er), 32'd1);
      chk("misaligned_rd_data", 0, rd, 32'd0);

      // interrupt set / clear, set-wins collision
      apb(1'b0, 1'b1, 32'h0000_0010, 32'h0000_0001, rd, er, wt);
      bus_idle();
      @(posedge Pclk); #1 ev_val = 8'h01;
      @(posedge Pclk); #1 ev_val = 8'h00;
      repeat (3) @(negedge Pclk);
      chk("irq_set", 0, 32'(irq_w[0]), 32'd1);
      apb(1'b0, 1'b0, 32'h0000_000C, '0, rd, er, wt);
      chk("irq_stat_set", 0, rd, 32'h0000_0001);
      ev_val = 8'h01;
      apb(1'b0, 1'b1, 32'h0000_000C, 32'h0000_0001, rd, er, wt);
      @(posedge Pclk); #1;
      m_psel = 1'b0; m_pen = 1'b0; ev_val = 8'h00;
      repeat (3) @(negedge Pclk);
      chk("irq_set_wins", 0, 32'(irq_w[0]), 32'd1);
      apb(1'b0, 1'b0, 32'h0000_000C, '0, rd, er, wt);
      chk("irq_stat_kept", 0, rd, 32'h0000_0001);
      apb(1'b0, 1'b1, 32'h0000_000C, 32'h0000_0001, rd, er, wt);
      bus_idle();
      repeat (3) @(negedge Pclk);
      chk("irq_cleared", 0, 32'(irq_w[0]), 32'd0);
      apb(1'b0, 1'b0, 32'h0000_000C, '0, rd, er, wt);
      chk("irq_stat_clear", 0, rd, 32'd0);
      bus_idle();

      // zero-wait instance and WCOUNT wrap
      @(posedge Pclk); #1;
      force dut_b.wcount_q = 16'hFFFE;
      preload = 1'b1;
      @(posedge Pclk); #1;
      release dut_b.wcount_q;
      preload = 1'b0;
      apb(1'b1, 1'b1, 32'h0000_0018, 32'h0BAD_F00D, rd, er, wt);
      chk("ws0_write_waits", 1, 32'(wt), 32'd0);
      apb(1'b1, 1'b0, 32'h0000_0014, '0, rd, er, wt);
      chk("ws0_read_waits", 1, 32'(wt), 32'd0);
      chk("wcount_ffff", 1, rd, 32'h0000_FFFF);
      apb(1'b1, 1'b1, 32'hFFFF_FFE0, 32'h0000_0042, rd, er, wt);
      apb(1'b1, 1'b0, 32'h0000_0014, '0, rd, er, wt);
      chk("wcount_wrap", 1, rd, 32'd0);
      apb(1'b1, 1'b0, 32'h0000_0000, '0, rd, er, wt);
      chk("upper_addr_ignored", 1, rd, 32'h0000_0042);

      // abort in a wait state leaves the target untouched
      apb(1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, rd, er, wt);
      abort_wr(32'h0000_0008, 32'h2222_2222);
      apb(1'b0, 1'b0, 32'h0000_0008, '0, rd, er, wt);
      chk("abort_scratch", 0, rd, 32'h1111_1111);
      bus_idle();

      // reset during an access phase
      @(posedge Pclk); #1;
      m_tgt = 1'b0; m_psel = 1'b1; m_pen = 1'b0; m_write = 1'b1;
      m_addr = 32'h0000_0008; m_wdata = 32'h3333_3333;
      @(posedge Pclk); #1;
      m_pen = 1'b1; Preset = 1'b1;
      @(posedge Pclk); #1;
      m_psel = 1'b0; m_pen = 1'b0;
      @(posedge Pclk); #1 Preset = 1'b0;
      @(negedge Pclk);
      chk("rst_ctrl_a", 0, ctrl_w[0], 32'd0);
      chk("rst_ctrl_b", 1, ctrl_w[1], 32'd0);
      chk("rst_pready", 0, 32'(rdy_w[0]), 32'd0);
      chk("rst_irq",    0, 32'(irq_w[0]), 32'd0);
      apb(1'b0, 1'b0, 32'h0000_0008, '0, rd, er, wt);
      chk("rst_scratch", 0, rd, 32'd0);

      // randomized traffic against the model
      ev_rand = 1'b1; st_rand = 1'b1;
      for (int n = 0; n < 400; n++) begin
         tgt  = 1'($urandom_range(0, 1));
         wr   = 1'($urandom_range(0, 1));
         addr = $urandom;
         if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
         if (!tgt && $urandom_range(0, 15) == 0) abort_wr(addr, $urandom);
         else apb(tgt, wr, addr, $urandom, rd, er, wt);
         if ($urandom_range(0, 3) == 0) bus_idle();
      end
      bus_idle();
      repeat (4) @(posedge Pclk);
      @(negedge Pclk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      repeat (90000) @(posedge Pclk);
      $display("FAIL watchdog: simulation did not finish, %0d cycles elapsed", 90000);
      $fatal(1, "watchdog");
   end

endmodule
